// File: rtl/dut_mem.sv
// Single-port synchronous RAM with a registered, write-through read port.
// Reset clears both the read register and every stored word on the same edge.
module dut_mem #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;

    // Write-first: the word being written is forwarded to out on the same edge.
    always_comb begin
        mem_d = mem_q;
        out_d = out_q;
        if (we) begin
            mem_d[addr] = data;
            out_d       = data;
        end else begin
            out_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            out_q <= out_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_dut_mem.sv
// Directed self-checking bench for dut_mem: reset, fill/readback, random reads,
// read-after-write, write isolation and reset in the middle of a write sequence.
module tb_dut_mem;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] out;

    logic [DATA_W-1:0] model [DEPTH];
    int errors;
    int checks;

    dut_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .data  (data),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we    = 1'b1;
        addr  = 6'd5;
        data  = 16'hFFFF;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_out cycle %0d: out=%h expected=%h", n, out, 16'h0000);
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b1;
        we    = 1'b0;
        addr  = 6'd5;
        tick();
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read_addr5: out=%h expected=%h", out, 16'h0000);
        end
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] w;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w    = 16'(i * 16'h0401) ^ 16'hA5A5;
            we   = 1'b1;
            addr = ADDR_W'(i);
            data = w;
            tick();
            model[i] = w;
            checks++;
            if (out !== w) begin
                errors++;
                $display("FAIL fill_write addr %0d: out=%h expected=%h", i, out, w);
            end
        end
        we = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            addr = ADDR_W'(i);
            data = 16'h0000;
            tick();
            checks++;
            if (out !== model[i]) begin
                errors++;
                $display("FAIL fill_read addr %0d: out=%h expected=%h", i, out, model[i]);
            end
        end
        // Wrap from the top address back to 0.
        addr = 6'd0;
        tick();
        checks++;
        if (out !== 16'hA5A5) begin
            errors++;
            $display("FAIL fill_read_addr0_after63: out=%h expected=%h", out, 16'hA5A5);
        end
    endtask

    task automatic test_random_read();
        int unsigned a;
        we = 1'b0;
        for (int n = 0; n < 100; n++) begin
            a    = $urandom_range(0, DEPTH - 1);
            addr = ADDR_W'(a);
            data = 16'($urandom);
            tick();
            checks++;
            if (out !== model[a]) begin
                errors++;
                $display("FAIL random_read addr %0d: out=%h expected=%h", a, out, model[a]);
            end
        end
    endtask

    task automatic test_read_after_write();
        we = 1'b1; addr = 6'd17; data = 16'h1234;
        tick();
        model[17] = 16'h1234;
        we = 1'b0; data = 16'h0000;
        tick();
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL raw_first: out=%h expected=%h", out, 16'h1234);
        end
        we = 1'b1; data = 16'hBEEF;
        tick();
        model[17] = 16'hBEEF;
        we = 1'b0; data = 16'h0000;
        tick();
        checks++;
        if (out !== 16'hBEEF) begin
            errors++;
            $display("FAIL raw_overwrite: out=%h expected=%h", out, 16'hBEEF);
        end
    endtask

    task automatic test_write_isolation();
        we = 1'b1; addr = 6'd3; data = 16'h00FF;
        tick();
        model[3] = 16'h00FF;
        we = 1'b0;
        addr = 6'd2;
        tick();
        checks++;
        if (out !== model[2]) begin
            errors++;
            $display("FAIL isolation_addr2: out=%h expected=%h", out, model[2]);
        end
        addr = 6'd4;
        tick();
        checks++;
        if (out !== model[4]) begin
            errors++;
            $display("FAIL isolation_addr4: out=%h expected=%h", out, model[4]);
        end
        addr = 6'd3;
        tick();
        checks++;
        if (out !== 16'h00FF) begin
            errors++;
            $display("FAIL isolation_addr3: out=%h expected=%h", out, 16'h00FF);
        end
    endtask

    task automatic test_mid_reset();
        logic [ADDR_W-1:0] probe [4];
        probe[0] = 6'd10; probe[1] = 6'd11; probe[2] = 6'd17; probe[3] = 6'd63;
        we = 1'b1; addr = 6'd10; data = 16'h5555;
        tick();
        checks++;
        if (out !== 16'h5555) begin
            errors++;
            $display("FAIL mid_reset_write10: out=%h expected=%h", out, 16'h5555);
        end
        rst_n = 1'b0; we = 1'b1; addr = 6'd11; data = 16'h6666;
        tick();
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_out: out=%h expected=%h", out, 16'h0000);
        end
        for (int unsigned i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b1; we = 1'b0; data = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            addr = probe[k];
            tick();
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL mid_reset_read addr %0d: out=%h expected=%h", probe[k], out, 16'h0000);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        we     = 1'b0;
        addr   = '0;
        data   = '0;
        #2;
        test_reset();
        test_fill();
        test_random_read();
        test_read_after_write();
        test_write_isolation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
